// File: rtl/conv_pkg.sv
// Shared constants and types for the time-multiplexed 3x3 convolution sequencer.
package conv_pkg;

  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StAcc,
    StWrite,
    StDone
  } state_e;

  // Neighbourhood offsets for tap k = ky*3 + kx, relative to the output pixel.
  localparam int TAP_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate unit: clear-to-bias, then one 8x8 product per enabled cycle.
module conv_mac #(
  parameter int unsigned DW    = conv_pkg::DW,
  parameter int unsigned ACC_W = conv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    bias,
  input  logic [DW-1:0]    pix,
  input  logic [DW-1:0]    coef,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_d, acc_q;

  // Next accumulator value; clear wins over enable, sum wraps at ACC_W bits.
  always_comb begin
    prod  = pix * coef;
    acc_d = acc_q;
    if (clr) begin
      acc_d = ACC_W'(bias);
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_sched.sv
// Row/column/tap scan sequencer driving one MAC over an image RAM into a feature-map RAM.
module conv_sched #(
  parameter int unsigned IMG_W = conv_pkg::IMG_W,
  parameter int unsigned IMG_H = conv_pkg::IMG_H,
  parameter int unsigned DW    = conv_pkg::DW,
  parameter int unsigned ACC_W = conv_pkg::ACC_W,
  parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9*DW-1:0]   kernel,
  input  logic [DW-1:0]     bias,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     img_addr,
  output logic              img_rd,
  input  logic [DW-1:0]     img_data,
  output logic [AW-1:0]     out_addr,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_we,
  input  logic              out_ready
);

  import conv_pkg::*;

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [3:0]      tap_q, tap_d;
  logic [9*DW-1:0] kernel_q, kernel_d;
  logic [DW-1:0]   bias_q, bias_d;

  logic [AW-1:0]   pix_addr;
  logic [AW-1:0]   fetch_addr;
  int              tap_off;
  logic            border, last_pix, col_wrap, nxt_border;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_col;
  logic            mac_clr, mac_en;
  logic [DW-1:0]   coef;
  logic [ACC_W-1:0] acc;

  function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (r == '0) || (r == RW'(IMG_H - 1)) || (c == '0) || (c == CW'(IMG_W - 1));
  endfunction

  // Pixel position, neighbourhood read address and scan advance.
  always_comb begin
    pix_addr = AW'(32'(row_q) * IMG_W + 32'(col_q));
    tap_off  = 0;
    for (int k = 0; k < 9; k++) begin
      if (tap_q == 4'(k)) tap_off = TAP_DY[k] * int'(IMG_W) + TAP_DX[k];
    end
    fetch_addr = AW'(int'(pix_addr) + tap_off);
    border     = is_border(row_q, col_q);
    col_wrap   = (col_q == CW'(IMG_W - 1));
    last_pix   = col_wrap && (row_q == RW'(IMG_H - 1));
    nxt_col    = col_wrap ? '0 : col_q + CW'(1);
    nxt_row    = col_wrap ? row_q + RW'(1) : row_q;
    nxt_border = is_border(nxt_row, nxt_col);
  end

  // Data returning this cycle belongs to the tap issued last cycle, hence tap_q - 1.
  always_comb begin
    coef = '0;
    for (int k = 0; k < 9; k++) begin
      if (tap_q == 4'(k + 1)) coef = kernel_q[k*DW +: DW];
    end
  end

  // Next-state, counter and MAC control decode.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    tap_d    = tap_q;
    kernel_d = kernel_q;
    bias_d   = bias_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          kernel_d = kernel;
          bias_d   = bias;
          row_d    = '0;
          col_d    = '0;
          tap_d    = '0;
          state_d  = is_border('0, '0) ? StWrite : StFetch;
        end
      end
      StFetch: begin
        if (tap_q == '0) mac_clr = 1'b1;
        else             mac_en  = 1'b1;
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'd8) state_d = StAcc;
      end
      StAcc: begin
        mac_en  = 1'b1;
        state_d = StWrite;
      end
      StWrite: begin
        if (out_ready) begin
          if (last_pix) begin
            state_d = StDone;
          end else begin
            row_d   = nxt_row;
            col_d   = nxt_col;
            tap_d   = '0;
            state_d = nxt_border ? StWrite : StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and latched kernel/bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      tap_q    <= '0;
      kernel_q <= '0;
      bias_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      tap_q    <= tap_d;
      kernel_q <= kernel_d;
      bias_q   <= bias_d;
    end
  end

  conv_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .bias (bias_q),
    .pix  (img_data),
    .coef (coef),
    .acc  (acc)
  );

  // Moore outputs; addresses and data are forced to zero outside their owning state.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    img_rd   = (state_q == StFetch);
    img_addr = img_rd ? fetch_addr : '0;
    out_we   = (state_q == StWrite);
    out_addr = out_we ? pix_addr : '0;
    out_data = (out_we && !border) ? acc : '0;
  end

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched with a frame-level convolution model.
module tb_conv_sched;

  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [71:0] kernel = '0;
  logic [7:0]  bias = '0;
  logic        busy, done, img_rd, out_we;
  logic [9:0]  img_addr, out_addr;
  logic [7:0]  img_data = '0;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  conv_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kernel    (kernel),
    .bias      (bias),
    .busy      (busy),
    .done      (done),
    .img_addr  (img_addr),
    .img_rd    (img_rd),
    .img_data  (img_data),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_we    (out_we),
    .out_ready (out_ready)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mem [N];
  int km [9];
  int bm;
  int exp_map [N];
  int got_map [N];
  int wr_idx = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0;
  bit rdy_rand = 1'b0;
  logic        prev_we = 1'b0, prev_rdy = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference feature map straight from the convolution definition.
  task automatic build_model();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int s;
        if (r == 0 || c == 0 || r == H - 1 || c == W - 1) begin
          exp_map[r*W+c] = 0;
        end else begin
          s = bm;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              s += mem[(r+ky-1)*W + (c+kx-1)] * km[ky*3+kx];
          exp_map[r*W+c] = s % 65536;
        end
      end
    end
    for (int k = 0; k < 9; k++) kernel[k*8 +: 8] = 8'(km[k]);
    bias = 8'(bm);
  endtask

  // Image RAM: one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (img_rd) img_data <= (int'(img_addr) < N) ? 8'(mem[img_addr]) : 8'h00;
  end

  // Write-side backpressure.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Per-cycle compare of the write stream, stall stability and read exclusion.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_we = 1'b0;
    end else begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (img_rd) rd_cnt++;
      if (out_we) begin
        check("no_read_while_writing", int'(img_rd), 0);
        if (prev_we && !prev_rdy) begin
          check("stall_addr_hold", int'(out_addr), int'(prev_addr));
          check("stall_data_hold", int'(out_data), int'(prev_data));
        end
        if (out_ready) begin
          if (wr_idx < N) begin
            check("wr_addr", int'(out_addr), wr_idx);
            check("wr_data", int'(out_data), exp_map[wr_idx]);
          end else begin
            check("wr_count_overflow", wr_idx, N - 1);
          end
          if (int'(out_addr) < N) got_map[out_addr] = int'(out_data);
          wr_idx++;
        end
      end
      prev_we   = out_we;
      prev_rdy  = out_ready;
      prev_addr = out_addr;
      prev_data = out_data;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_idx = 0;
  endtask

  task automatic run_frame(input bit rand_rdy, input bit disturb, input bit timing);
    build_model();
    rdy_rand = rand_rdy;
    for (int i = 0; i < N; i++) got_map[i] = -1;
    pulse_start();
    for (int n = 0; n < 40000 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n == 1000) begin
        start  = 1'b1;
        kernel = ~kernel;
        bias   = ~bias;
      end
      if (disturb && n == 1001) start = 1'b0;
    end
    check("frame_done_seen", int'(done_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    rdy_rand = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("writes", wr_idx, N);
    check("reads", rd_cnt, (W - 2) * (H - 2) * 9);
    check("busy_after_done", int'(busy), 0);
    if (timing) begin
      check("done_cycle", done_cyc, 7545);
      check("busy_cycles", busy_cnt, 7545);
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < N; i++) mem[i] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) km[k] = int'($urandom_range(0, 255));
    bm = int'($urandom_range(0, 255));
  endtask

  initial begin
    int found;
    int rd_mark;
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_img_rd", int'(img_rd), 0);
    check("rst_out_we", int'(out_we), 0);
    check("rst_img_addr", int'(img_addr), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All ones: interior 9, border 0, exact frame timing.
    for (int i = 0; i < N; i++) mem[i] = 1;
    for (int k = 0; k < 9; k++) km[k] = 1;
    bm = 0;
    run_frame(1'b0, 1'b0, 1'b1);
    check("model_ones_interior", exp_map[29], 9);
    check("dut_ones_interior", got_map[29], 9);
    check("dut_ones_corner", got_map[0], 0);
    check("dut_ones_last", got_map[N-1], 0);
    check("dut_ones_edge", got_map[2*W + W - 1], 0);

    // All 255: accumulator wraps.
    for (int i = 0; i < N; i++) mem[i] = 255;
    for (int k = 0; k < 9; k++) km[k] = 255;
    bm = 255;
    run_frame(1'b0, 1'b0, 1'b0);
    check("model_wrap", exp_map[29], 61192);
    check("dut_wrap", got_map[400], 61192);

    // Ramp image through an identity kernel.
    for (int i = 0; i < N; i++) mem[i] = i % 256;
    for (int k = 0; k < 9; k++) km[k] = (k == 4) ? 1 : 0;
    bm = 3;
    run_frame(1'b0, 1'b0, 1'b0);
    check("model_ramp", exp_map[300], 47);
    check("dut_ramp_300", got_map[300], 47);
    check("dut_ramp_285", got_map[285], 32);

    // Random data, random backpressure, ignored restart and kernel change mid-frame.
    randomize_frame();
    run_frame(1'b1, 1'b1, 1'b0);

    // Reset during FETCH of pixel (5,5).
    randomize_frame();
    build_model();
    pulse_start();
    found = 0;
    for (int n = 0; n < 5000 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (wr_idx == 5 * W + 5 && img_rd) found = 1;
    end
    check("reached_pixel_5_5", found, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_img_rd", int'(img_rd), 0);
    check("abort_out_we", int'(out_we), 0);
    check("abort_img_addr", int'(img_addr), 0);
    check("abort_out_addr", int'(out_addr), 0);
    check("abort_out_data", int'(out_data), 0);
    rd_mark = rd_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_more_writes", wr_idx, 5 * W + 5);
    check("abort_no_more_reads", rd_cnt, rd_mark);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", int'(busy), 0);

    // Fresh start after the abort completes normally.
    randomize_frame();
    run_frame(1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencer for a single time-multiplexed 3x3 convolution MAC engine over a 28x28 8-bit image held in an external single-port RAM. It replaces the fully parallel combinational convolution with a small datapath: one multiply-accumulate per cycle, driven by a row/column/tap scan FSM. It writes a complete 28x28 16-bit feature map to an output RAM, with every border pixel written as 0. It sits between the image buffer RAM and the feature-map RAM, and is started by the layer-level controller.

## Interface
- IMG_W, 28, image/output width in pixels
- IMG_H, 28, image/output height in pixels
- DW, 8, pixel/kernel/bias width (unsigned)
- ACC_W, 16, accumulator and output width
- AW, 10, address width (clog2(IMG_W*IMG_H))

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- kernel  in  9*DW  flattened 3x3 kernel, tap k = ky*3+kx at [k*DW +: DW]; latched on accepted start
- bias  in  DW  bias, zero-extended; latched on accepted start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after last output write accepted
- img_addr  out  AW  image RAM read address, row*IMG_W+col
- img_rd  out  1  image RAM read enable
- img_data  in  DW  read data, valid exactly 1 cycle after img_rd
- out_addr  out  AW  feature-map write address
- out_data  out  ACC_W  feature-map write data
- out_we  out  1  write request; held stable until out_ready
- out_ready  in  1  write accepted when out_we && out_ready

## Operation
- FSM states: IDLE, FETCH, ACC, WRITE, DONE.
- IDLE: on start, latch kernel/bias, set row=col=0, go to WRITE if (0,0) is border (always), else FETCH.
- Scan order: row-major over all IMG_H*IMG_W outputs.
- Border pixel (row or col equal to 0 or max): go directly to WRITE with out_data=0; no image reads.
- Interior pixel: FETCH issues 9 reads, taps k=0..8 in order, at address (row+ky-1)*IMG_W+(col+kx-1). Accumulator is initialised to zero-extended bias on the first FETCH cycle. Each returned img_data*kernel[k] (8x8 unsigned) is added mod 2^ACC_W one cycle after its read. ACC is a single cycle that absorbs tap 8, then the FSM goes to WRITE.
- WRITE: assert out_we with out_addr=row*IMG_W+col. On out_ready, advance col (wrap to 0, increment row). After the last pixel go to DONE, otherwise go to FETCH or WRITE per border test.
- DONE: pulse done, drop busy, return to IDLE.
- start in any state other than IDLE is ignored. Kernel/bias changes after an accepted start have no effect until the next start.
- Arithmetic: sum = bias + Σ img*kernel, truncated to ACC_W bits (wrap, no saturation).

## Timing
- Reset (rst=0, async): state=IDLE; busy, done, img_rd, out_we = 0; img_addr, out_addr, out_data = 0; latched kernel/bias cleared.
- Reset mid-run aborts immediately: no further reads or writes, and no done pulse.
- Interior pixel: 9 FETCH + 1 ACC + 1 WRITE = 11 cycles with out_ready=1. Border pixel: 1 cycle.
- Full frame at 28x28 with out_ready held high: 676*11 + 108 = 7544 cycles from the first post-start cycle to the last write. done follows 1 cycle later. busy is high for 7545 cycles.
- out_ready low stalls in WRITE. out_we, out_addr and out_data must stay stable, and no reads are issued during the stall.
- img_rd is high only in FETCH.

## Structure
- Package conv_pkg holds: IMG_W/IMG_H/DW/ACC_W defaults, the state enum, and the tap-offset constants (dy, dx per k).
- Sub-module conv_mac: registered accumulator with clear-to-bias, an enable, and an 8x8 unsigned multiply with wrap-around add. It is instantiated once.
- The FSM and counters (row, col, tap) live in conv_sched.

## Test plan
- Image all 1, kernel all 1, bias 0, out_ready=1 -> interior outputs 9, border outputs 0, done exactly 7545 cycles after start.
- Image all 255, kernel all 255, bias 255 -> interior outputs 61192 (585480 mod 65536), confirming wrap.
- Ramp image pixel=(addr mod 256), kernel = identity centre tap 1, bias 3 -> interior out[addr] = (addr mod 256)+3.
- out_ready driven pseudo-random 50% -> same map as the ideal run; out_* stable across every stall; no img_rd during stalls.
- Second start mid-frame, and kernel changed mid-frame -> both ignored; results match the originally latched kernel.
- Reset asserted in FETCH of pixel (5,5) -> all outputs 0 asynchronously, state IDLE, no done. A new start then completes normally.
